// File: rtl/soc_stub_pkg.sv
// Shared widths, AD48 instruction layout and sizing helpers for the
// simple SoC stub, its interrupt controller and the AD48 core.
package soc_stub_pkg;

  localparam int XLEN          = 48;
  localparam int IRQ_MAX_LINES = 16;
  localparam int AD48_NREGS    = 16;
  localparam logic [XLEN-1:0] IRQ_VEC = 48'h100;

  typedef enum logic [7:0] {
    OP_NOP  = 8'h00,
    OP_LDI  = 8'h01,
    OP_LD   = 8'h02,
    OP_ST   = 8'h03,
    OP_ADD  = 8'h04,
    OP_BEQZ = 8'h05,
    OP_JMP  = 8'h06,
    OP_EI   = 8'h07,
    OP_RETI = 8'h08,
    OP_HALT = 8'hFF
  } ad48_op_e;

  typedef struct packed {
    ad48_op_e    op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [31:0] imm;
  } ad48_instr_t;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } core_state_e;

  // Index width for n entries; never below 1 so a single line still gets a port bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ad48_core.sv
// Minimal single-cycle AD48 core with its instruction and data memories.
// Word format: op[47:40] rd[39:36] rs[35:32] imm[31:0]; interrupts vector to IRQ_VEC.
//
// state  | meaning
// S_RUN  | fetch and execute one instruction per cycle, interrupts accepted when enabled
// S_HALT | HALT retired; pc frozen on the HALT word until reset

module ad48_mem
  import soc_stub_pkg::*;
#(
  parameter int WORDS = 16384,
  parameter int AW    = 14
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

module ad48_core
  import soc_stub_pkg::*;
#(
  parameter int IM_WORDS = 16384,
  parameter int DM_WORDS = 16384,
  parameter int IRQ_ID_W = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                irq_req,
  input  logic [IRQ_ID_W-1:0] irq_id,
  output logic                irq_ack,
  output logic                halt,
  output logic [XLEN-1:0]     pc
);

  localparam int IA_W = clog2_min1(IM_WORDS);
  localparam int DA_W = clog2_min1(DM_WORDS);

  core_state_e     state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            ie_q, ie_d;
  logic [XLEN-1:0] rf_q [AD48_NREGS];
  logic [XLEN-1:0] rf_d [AD48_NREGS];

  logic [XLEN-1:0] im_rdata;
  logic [XLEN-1:0] dm_rdata;
  logic [XLEN-1:0] dm_wdata;
  logic [DA_W-1:0] dm_addr;
  logic            dm_we;
  logic            take_irq;
  ad48_instr_t     instr;

  ad48_mem #(.WORDS(IM_WORDS), .AW(IA_W)) IMEM (
    .clk   (clk),
    .we    (1'b0),
    .addr  (pc_q[IA_W-1:0]),
    .wdata ('0),
    .rdata (im_rdata)
  );

  ad48_mem #(.WORDS(DM_WORDS), .AW(DA_W)) DMEM (
    .clk   (clk),
    .we    (dm_we),
    .addr  (dm_addr),
    .wdata (dm_wdata),
    .rdata (dm_rdata)
  );

  assign instr    = ad48_instr_t'(im_rdata);
  assign take_irq = (state_q == S_RUN) && irq_req && ie_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == S_RUN) && !take_irq && (instr.op == OP_HALT)) begin
      state_d = S_HALT;
    end
  end

  always_comb begin
    halt    = (state_q == S_HALT);
    irq_ack = take_irq;
  end

  // Interrupt entry replaces the instruction at pc; that instruction runs after RETI.
  always_comb begin
    pc_d     = pc_q;
    epc_d    = epc_q;
    ie_d     = ie_q;
    rf_d     = rf_q;
    dm_we    = 1'b0;
    dm_wdata = rf_q[instr.rd];
    dm_addr  = DA_W'(rf_q[instr.rs] + XLEN'(instr.imm));
    if (take_irq) begin
      epc_d                 = pc_q;
      ie_d                  = 1'b0;
      pc_d                  = IRQ_VEC;
      rf_d[AD48_NREGS-1]    = XLEN'(irq_id);
    end else if (state_q == S_RUN) begin
      pc_d = pc_q + XLEN'(1);
      case (instr.op)
        OP_LDI:  rf_d[instr.rd] = XLEN'(instr.imm);
        OP_LD:   rf_d[instr.rd] = dm_rdata;
        OP_ST:   dm_we = 1'b1;
        OP_ADD:  rf_d[instr.rd] = rf_q[instr.rd] + rf_q[instr.rs];
        OP_BEQZ: begin
          if (rf_q[instr.rd] == '0) begin
            pc_d = XLEN'(instr.imm);
          end
        end
        OP_JMP:  pc_d = XLEN'(instr.imm);
        OP_EI:   ie_d = 1'b1;
        OP_RETI: begin
          pc_d = epc_q;
          ie_d = 1'b1;
        end
        OP_HALT: pc_d = pc_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q  <= '0;
      epc_q <= '0;
      ie_q  <= 1'b0;
      for (int i = 0; i < AD48_NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      ie_q  <= ie_d;
      rf_q  <= rf_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/soc_irq_ctrl.sv
// External interrupt front end: per-line 2-flop synchroniser, rising-edge
// detect, pending latch with ack clear, and lowest-index-first priority encode.
module soc_irq_ctrl
  import soc_stub_pkg::*;
#(
  parameter  int IRQ_LINES = 4,
  localparam int IRQ_ID_W  = clog2_min1(IRQ_LINES)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [IRQ_LINES-1:0] irq_lines,
  input  logic                 halt,
  input  logic                 irq_ack,
  output logic                 irq_req,
  output logic [IRQ_ID_W-1:0]  irq_id
);

  logic [IRQ_LINES-1:0] meta_q, meta_d;
  logic [IRQ_LINES-1:0] sync_q, sync_d;
  logic [IRQ_LINES-1:0] sync_dly_q, sync_dly_d;
  logic [IRQ_LINES-1:0] pend_q, pend_d;
  logic [IRQ_LINES-1:0] rise;
  logic [IRQ_LINES-1:0] ack_mask;

  always_comb begin
    meta_d     = irq_lines;
    sync_d     = meta_q;
    sync_dly_d = sync_q;
  end

  assign rise = sync_q & ~sync_dly_q;

  always_comb begin
    ack_mask = '0;
    for (int i = 0; i < IRQ_LINES; i++) begin
      ack_mask[i] = irq_ack && (irq_id == IRQ_ID_W'(i));
    end
  end

  // A new edge on a bit being acked in the same cycle keeps the bit set.
  always_comb begin
    pend_d = (pend_q & ~ack_mask) | rise;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q     <= '0;
      sync_q     <= '0;
      sync_dly_q <= '0;
      pend_q     <= '0;
    end else begin
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      sync_dly_q <= sync_dly_d;
      pend_q     <= pend_d;
    end
  end

  always_comb begin
    irq_id = '0;
    for (int i = IRQ_LINES - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        irq_id = IRQ_ID_W'(i);
      end
    end
  end

  assign irq_req = (|pend_q) & ~halt;

endmodule

// File: rtl/simple_soc_stub.sv
// SoC top for system simulation: reset conditioning for the AD48 core and
// a prioritised interrupt request built from asynchronous external lines.
module simple_soc_stub
  import soc_stub_pkg::*;
#(
  parameter int IM_WORDS  = 16384,
  parameter int DM_WORDS  = 16384,
  parameter int IRQ_LINES = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [IRQ_LINES-1:0] irq_lines
);

  localparam int IRQ_ID_W = clog2_min1(IRQ_LINES);

  if (IRQ_LINES < 1 || IRQ_LINES > IRQ_MAX_LINES) begin : g_param_check
    $fatal(1, "simple_soc_stub: IRQ_LINES=%0d outside 1..%0d", IRQ_LINES, IRQ_MAX_LINES);
  end

  logic [1:0]          rst_sync_q, rst_sync_d;
  logic                core_resetn;
  logic                irq_req;
  logic                irq_ack;
  logic [IRQ_ID_W-1:0] irq_id;
  logic                cpu_halt;
  logic [XLEN-1:0]     cpu_pc;

  // Assert immediately, release two clocks after resetn rises.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign core_resetn = rst_sync_q[1];

  soc_irq_ctrl #(.IRQ_LINES(IRQ_LINES)) u_irq_ctrl (
    .clk       (clk),
    .resetn    (core_resetn),
    .irq_lines (irq_lines),
    .halt      (cpu_halt),
    .irq_ack   (irq_ack),
    .irq_req   (irq_req),
    .irq_id    (irq_id)
  );

  ad48_core #(
    .IM_WORDS (IM_WORDS),
    .DM_WORDS (DM_WORDS),
    .IRQ_ID_W (IRQ_ID_W)
  ) CPU (
    .clk     (clk),
    .resetn  (core_resetn),
    .irq_req (irq_req),
    .irq_id  (irq_id),
    .irq_ack (irq_ack),
    .halt    (cpu_halt),
    .pc      (cpu_pc)
  );

endmodule

// File: tb/tb_simple_soc_stub.sv
// Bench for simple_soc_stub: reset release, interrupt latency/priority/ack,
// set-ack collision, a table of line patterns, random lines against a model, halt.
module tb_simple_soc_stub;

  localparam int NL = 4;
  localparam logic [7:0] T_NOP  = 8'h00;
  localparam logic [7:0] T_LDI  = 8'h01;
  localparam logic [7:0] T_LD   = 8'h02;
  localparam logic [7:0] T_ST   = 8'h03;
  localparam logic [7:0] T_ADD  = 8'h04;
  localparam logic [7:0] T_JMP  = 8'h06;
  localparam logic [7:0] T_EI   = 8'h07;
  localparam logic [7:0] T_RETI = 8'h08;
  localparam logic [7:0] T_HALT = 8'hFF;

  logic          clk;
  logic          resetn;
  logic [NL-1:0] irq_lines;
  int            total;
  int            bad;

  simple_soc_stub #(.IM_WORDS(16384), .DM_WORDS(16384), .IRQ_LINES(NL)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .irq_lines (irq_lines)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NL-1:0] lines;
    logic [NL-1:0] pend;
    logic [1:0]    id;
    logic          req;
  } vec_t;

  vec_t vecs [10];

  // model state for the random run
  logic [NL-1:0] h0, h1, h2, h3, pm, cur, flip;
  logic [1:0]    mid;
  logic [47:0]   da, db, dsum;
  int            n, errs;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] enc(input logic [7:0] op, input int rd, input int rs,
                                      input logic [31:0] imm);
    logic [3:0] r_d, r_s;
    r_d = rd[3:0];
    r_s = rs[3:0];
    return {op, r_d, r_s, imm};
  endfunction

  task automatic enter_reset();
    irq_lines = '0;
    resetn    = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  // returns at the negedge after the 2nd posedge following release
  task automatic leave_reset();
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_pend_clear(input string name, input int budget);
    int k;
    k = 0;
    while (dut.u_irq_ctrl.pend_q != '0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(dut.u_irq_ctrl.pend_q), 64'd0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    irq_lines = '0;
    resetn    = 1'b0;

    vecs[0] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[1] = '{4'b0001, 4'b0001, 2'd0, 1'b1};
    vecs[2] = '{4'b0010, 4'b0010, 2'd1, 1'b1};
    vecs[3] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[4] = '{4'b1000, 4'b1000, 2'd3, 1'b1};
    vecs[5] = '{4'b1100, 4'b1100, 2'd2, 1'b1};
    vecs[6] = '{4'b1010, 4'b1010, 2'd1, 1'b1};
    vecs[7] = '{4'b1111, 4'b1111, 2'd0, 1'b1};
    vecs[8] = '{4'b0110, 4'b0110, 2'd1, 1'b1};
    vecs[9] = '{4'b1001, 4'b1001, 2'd0, 1'b1};

    // idle program with interrupts enabled; handler returns at once
    dut.CPU.IMEM.mem[0]   = enc(T_EI, 0, 0, 0);
    dut.CPU.IMEM.mem[1]   = enc(T_JMP, 0, 0, 1);
    dut.CPU.IMEM.mem[256] = enc(T_RETI, 0, 0, 0);

    // ---- reset release
    errs = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (dut.core_resetn !== 1'b0 || dut.CPU.pc !== 48'd0 ||
          dut.u_irq_ctrl.pend_q !== 4'd0 || dut.irq_req !== 1'b0) errs++;
    end
    check("reset_hold", 64'(errs), 64'd0);
    resetn = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_p1_core_resetn", 64'(dut.core_resetn), 64'd0);
    check("rst_p1_pc", 64'(dut.CPU.pc), 64'd0);
    @(posedge clk); @(negedge clk);
    check("rst_p2_core_resetn", 64'(dut.core_resetn), 64'd1);
    check("rst_p2_pc", 64'(dut.CPU.pc), 64'd0);
    check("rst_p2_req", 64'(dut.irq_req), 64'd0);
    @(posedge clk); @(negedge clk);
    check("rst_p3_pc", 64'(dut.CPU.pc), 64'd1);

    // ---- single irq, held level
    irq_lines = 4'b0100;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    check("single_p2_pend", 64'(dut.u_irq_ctrl.pend_q), 64'd0);
    @(posedge clk); @(negedge clk);
    check("single_p3_pend", 64'(dut.u_irq_ctrl.pend_q), 64'h4);
    check("single_p3_req", 64'(dut.irq_req), 64'd1);
    check("single_p3_id", 64'(dut.irq_id), 64'd2);
    check("single_p3_ack", 64'(dut.irq_ack), 64'd1);
    @(posedge clk); @(negedge clk);
    check("single_acked", 64'(dut.u_irq_ctrl.pend_q), 64'd0);
    errs = 0;
    repeat (10) begin
      @(negedge clk);
      if (dut.u_irq_ctrl.pend_q !== 4'd0 || dut.irq_req !== 1'b0) errs++;
    end
    check("single_no_rerise", 64'(errs), 64'd0);
    irq_lines = '0;
    repeat (4) @(negedge clk);

    // ---- priority
    irq_lines = 4'b1010;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    check("prio_pend", 64'(dut.u_irq_ctrl.pend_q), 64'hA);
    check("prio_first_id", 64'(dut.irq_id), 64'd1);
    @(posedge clk); @(negedge clk);
    check("prio_after_ack1", 64'(dut.u_irq_ctrl.pend_q), 64'h8);
    check("prio_second_id", 64'(dut.irq_id), 64'd3);
    check("prio_second_req", 64'(dut.irq_req), 64'd1);
    wait_pend_clear("prio_after_ack2", 12);
    irq_lines = '0;
    repeat (4) @(negedge clk);

    // ---- set/ack collision: EI at 20 lines up the ack with a fresh edge
    enter_reset();
    for (int a = 0; a < 20; a++) dut.CPU.IMEM.mem[a] = enc(T_NOP, 0, 0, 0);
    dut.CPU.IMEM.mem[20] = enc(T_EI, 0, 0, 0);
    dut.CPU.IMEM.mem[21] = enc(T_JMP, 0, 0, 21);
    leave_reset();
    irq_lines = 4'b0001;
    repeat (6) @(negedge clk);
    check("coll_pre_pend", 64'(dut.u_irq_ctrl.pend_q), 64'h1);
    irq_lines = 4'b0000;
    n = 0;
    while (dut.CPU.pc !== 48'd19 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("coll_reach_pc19", 64'(dut.CPU.pc), 64'd19);
    irq_lines = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    check("coll_ack_cycle", 64'(dut.irq_ack), 64'd1);
    @(negedge clk);
    check("coll_pend0_kept", 64'(dut.u_irq_ctrl.pend_q[0]), 64'd1);
    check("coll_req_kept", 64'(dut.irq_req), 64'd1);
    wait_pend_clear("coll_final_clear", 12);
    irq_lines = '0;

    // ---- table of line patterns, interrupts never enabled
    for (int v = 0; v < 10; v++) begin
      enter_reset();
      dut.CPU.IMEM.mem[0] = enc(T_JMP, 0, 0, 0);
      leave_reset();
      irq_lines = vecs[v].lines;
      repeat (2) begin @(posedge clk); @(negedge clk); end
      check($sformatf("tbl%0d_early", v), 64'(dut.u_irq_ctrl.pend_q), 64'd0);
      @(posedge clk); @(negedge clk);
      check($sformatf("tbl%0d_pend", v), 64'(dut.u_irq_ctrl.pend_q), 64'(vecs[v].pend));
      check($sformatf("tbl%0d_id", v), 64'(dut.irq_id), 64'(vecs[v].id));
      check($sformatf("tbl%0d_req", v), 64'(dut.irq_req), 64'(vecs[v].req));
    end

    // ---- random lines vs. model: an event is a 0->1 step of the line as
    // sampled two clocks earlier; events accumulate until reset
    for (int seg = 0; seg < 6; seg++) begin
      enter_reset();
      leave_reset();
      h0 = '0; h1 = '0; h2 = '0; h3 = '0; pm = '0; cur = '0;
      for (int c = 0; c < 40; c++) begin
        flip = '0;
        for (int b = 0; b < NL; b++) flip[b] = ($urandom_range(3) == 0);
        cur = cur ^ flip;
        irq_lines = cur;
        @(posedge clk);
        @(negedge clk);
        h3 = h2; h2 = h1; h1 = h0; h0 = cur;
        pm = pm | (h2 & ~h3);
        mid = 2'd0;
        for (int b = NL - 1; b >= 0; b--) if (pm[b]) mid = 2'(b);
        check($sformatf("rand_s%0d_c%0d", seg, c),
              64'({dut.u_irq_ctrl.pend_q, dut.irq_id, dut.irq_req}),
              64'({pm, mid, (pm != '0)}));
      end
    end

    // ---- halt run with DMEM operands
    enter_reset();
    da   = {16'($urandom), 32'($urandom)};
    db   = {16'($urandom), 32'($urandom)};
    dsum = da + db;
    dut.CPU.DMEM.mem[16] = da;
    dut.CPU.DMEM.mem[17] = db;
    dut.CPU.DMEM.mem[18] = '0;
    dut.CPU.IMEM.mem[0]  = enc(T_LDI, 1, 0, 32'd16);
    dut.CPU.IMEM.mem[1]  = enc(T_LD, 2, 1, 32'd0);
    dut.CPU.IMEM.mem[2]  = enc(T_LD, 3, 1, 32'd1);
    dut.CPU.IMEM.mem[3]  = enc(T_ADD, 2, 3, 32'd0);
    dut.CPU.IMEM.mem[4]  = enc(T_ST, 2, 1, 32'd2);
    dut.CPU.IMEM.mem[5]  = enc(T_HALT, 0, 0, 0);
    leave_reset();
    n = 0;
    while (dut.CPU.halt !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", 64'(dut.CPU.halt), 64'd1);
    check("halt_pc", 64'(dut.CPU.pc), 64'd5);
    check("halt_dmem_sum", 64'(dut.CPU.DMEM.mem[18]), 64'(dsum));
    repeat (3) @(negedge clk);
    check("halt_pc_held", 64'(dut.CPU.pc), 64'd5);

    // ---- irq while halted, then async reset
    irq_lines = 4'b0100;
    errs = 0;
    repeat (6) begin
      @(negedge clk);
      if (dut.irq_req !== 1'b0) errs++;
    end
    check("halted_pend", 64'(dut.u_irq_ctrl.pend_q), 64'h4);
    check("halted_req_low", 64'(errs), 64'd0);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_pend", 64'(dut.u_irq_ctrl.pend_q), 64'd0);
    check("async_rst_halt", 64'(dut.CPU.halt), 64'd0);
    check("async_rst_core", 64'(dut.core_resetn), 64'd0);
    check("async_rst_pc", 64'(dut.CPU.pc), 64'd0);
    irq_lines = '0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
